// File: rtl/maze_pkg.sv
// +----------------------------------------------------------------------------+
// | maze_pkg: direction/heading types, solver states and turn helper functions  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package maze_pkg;

  typedef enum logic [1:0] {
    NORTH = 2'd0,
    WEST  = 2'd1,
    SOUTH = 2'd2,
    EAST  = 2'd3
  } dir_t;

  localparam logic [11:0] HDNG_N = 12'h000;
  localparam logic [11:0] HDNG_W = 12'h3FF;
  localparam logic [11:0] HDNG_S = 12'h7FF;
  localparam logic [11:0] HDNG_E = 12'hC00;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MOVE      = 3'd1,
    S_WAIT_MV   = 3'd2,
    S_DECIDE    = 3'd3,
    S_HDNG      = 3'd4,
    S_WAIT_HDNG = 3'd5,
    S_DONE      = 3'd6
  } solve_state_t;

  function automatic dir_t turn_left(input dir_t d);
    case (d)
      NORTH:   turn_left = WEST;
      WEST:    turn_left = SOUTH;
      SOUTH:   turn_left = EAST;
      default: turn_left = NORTH;
    endcase
  endfunction

  function automatic dir_t turn_right(input dir_t d);
    case (d)
      NORTH:   turn_right = EAST;
      EAST:    turn_right = SOUTH;
      SOUTH:   turn_right = WEST;
      default: turn_right = NORTH;
    endcase
  endfunction

  function automatic dir_t reverse(input dir_t d);
    case (d)
      NORTH:   reverse = SOUTH;
      SOUTH:   reverse = NORTH;
      EAST:    reverse = WEST;
      default: reverse = EAST;
    endcase
  endfunction

  function automatic logic [11:0] dir2hdng(input dir_t d);
    case (d)
      NORTH:   dir2hdng = HDNG_N;
      WEST:    dir2hdng = HDNG_W;
      SOUTH:   dir2hdng = HDNG_S;
      default: dir2hdng = HDNG_E;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/maze_solve.sv
// +----------------------------------------------------------------------------+
// | maze_solve: wall-following solver issuing move/heading commands to navigate |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module maze_solve
  import maze_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_md,
  input  logic        cmd0,
  input  logic        lft_opn,
  input  logic        rght_opn,
  input  logic        mv_cmplt,
  input  logic        sol_cmplt,
  output logic        strt_mv,
  output logic        strt_hdng,
  output logic        stp_lft,
  output logic        stp_rght,
  output logic [11:0] dsrd_hdng
);

  solve_state_t r_state;
  dir_t         r_dir;
  logic         r_aff;
  dir_t         w_next_dir;

  // Preferred wall side first, then the opposite side, otherwise turn around.
  always_comb begin
    w_next_dir = reverse(r_dir);
    if (r_aff) begin
      if (lft_opn)       w_next_dir = turn_left(r_dir);
      else if (rght_opn) w_next_dir = turn_right(r_dir);
    end else begin
      if (rght_opn)      w_next_dir = turn_right(r_dir);
      else if (lft_opn)  w_next_dir = turn_left(r_dir);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dir     <= NORTH;
      r_aff     <= 1'b0;
      dsrd_hdng <= HDNG_N;
      strt_mv   <= 1'b0;
      strt_hdng <= 1'b0;
      stp_lft   <= 1'b0;
      stp_rght  <= 1'b0;
    end else begin
      strt_mv   <= 1'b0;
      strt_hdng <= 1'b0;
      // Command mode aborts a solve from anywhere; heading is kept.
      if (cmd_md && (r_state != S_IDLE)) begin
        r_state  <= S_IDLE;
        stp_lft  <= 1'b0;
        stp_rght <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!cmd_md) begin
              r_state  <= S_MOVE;
              r_aff    <= cmd0;
              stp_lft  <= cmd0;
              stp_rght <= ~cmd0;
              strt_mv  <= 1'b1;
            end
          end
          S_MOVE: r_state <= S_WAIT_MV;
          S_WAIT_MV: begin
            if (mv_cmplt) begin
              if (sol_cmplt) begin
                r_state  <= S_DONE;
                stp_lft  <= 1'b0;
                stp_rght <= 1'b0;
              end else begin
                r_state <= S_DECIDE;
              end
            end
          end
          S_DECIDE: begin
            r_dir     <= w_next_dir;
            dsrd_hdng <= dir2hdng(w_next_dir);
            strt_hdng <= 1'b1;
            r_state   <= S_HDNG;
          end
          S_HDNG: r_state <= S_WAIT_HDNG;
          S_WAIT_HDNG: begin
            if (mv_cmplt) begin
              r_state <= S_MOVE;
              strt_mv <= 1'b1;
            end
          end
          S_DONE: r_state <= S_DONE;
          default: begin
            r_state  <= S_IDLE;
            stp_lft  <= 1'b0;
            stp_rght <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_maze_solve.sv
// +----------------------------------------------------------------------------+
// | tb_maze_solve: vector table plus scoreboard of expected command pulses      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_maze_solve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_md, cmd0, lft_opn, rght_opn, mv_cmplt, sol_cmplt;
  logic        strt_mv, strt_hdng, stp_lft, stp_rght;
  logic [11:0] dsrd_hdng;

  maze_solve dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_md    (cmd_md),
    .cmd0      (cmd0),
    .lft_opn   (lft_opn),
    .rght_opn  (rght_opn),
    .mv_cmplt  (mv_cmplt),
    .sol_cmplt (sol_cmplt),
    .strt_mv   (strt_mv),
    .strt_hdng (strt_hdng),
    .stp_lft   (stp_lft),
    .stp_rght  (stp_rght),
    .dsrd_hdng (dsrd_hdng)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit          is_hdng;
    logic [11:0] hdng;
    bit          sl;
    bit          sr;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          aff;
    bit          lft;
    bit          rght;
    logic [11:0] exp_hdng;
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   prev_pulse = 1'b0;
  bit   cur_aff;
  logic [11:0] cur_hd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every command pulse must match the next queued expectation, cycle included.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (strt_mv || strt_hdng) begin
        chk("pulse_back_to_back", 32'(prev_pulse), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 32'({strt_mv, strt_hdng}), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pulse_kind", 32'({strt_mv, strt_hdng}), e.is_hdng ? 32'd1 : 32'd2);
          chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
          chk("pulse_hdng", 32'(dsrd_hdng), 32'(e.hdng));
          chk("pulse_stp", 32'({stp_lft, stp_rght}), 32'({e.sl, e.sr}));
        end
      end
      prev_pulse <= strt_mv || strt_hdng;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input bit h, input logic [11:0] hd, input int c);
    exp_t e;
    e.is_hdng = h;
    e.hdng    = hd;
    e.sl      = cur_aff;
    e.sr      = ~cur_aff;
    e.cyc     = c;
    sb.push_back(e);
  endtask

  // Force IDLE, then release command mode; ends in WAIT_MV.
  task automatic start_solve(input bit a);
    cmd_md = 1'b1;
    tick();
    cmd0    = a;
    cur_aff = a;
    cmd_md  = 1'b0;
    expect_pulse(1'b0, cur_hd, cyc + 1);
    tick();
    tick();
    cmd0 = 1'b0;
  endtask

  // From WAIT_MV: finish move, decide, finish heading; ends in WAIT_MV.
  task automatic move_done(input bit l, input bit r, input logic [11:0] new_hd);
    lft_opn  = l;
    rght_opn = r;
    mv_cmplt = 1'b1;
    expect_pulse(1'b1, new_hd, cyc + 2);
    tick();
    mv_cmplt = 1'b0;
    tick();
    lft_opn  = 1'b0;
    rght_opn = 1'b0;
    tick();
    tick();
    cur_hd   = new_hd;
    mv_cmplt = 1'b1;
    expect_pulse(1'b0, new_hd, cyc + 1);
    tick();
    mv_cmplt = 1'b0;
    tick();
    tick();
  endtask

  vec_t tbl[8];

  initial begin
    // Each row turns from the heading left by the previous row (start NORTH).
    tbl[0] = '{1'b1, 1'b1, 1'b0, 12'h3FF};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 12'h000};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 12'h3FF};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 12'hC00};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 12'h7FF};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 12'hC00};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 12'h3FF};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 12'h000};

    rst_n = 1'b0; cmd_md = 1'b1; cmd0 = 1'b0; lft_opn = 1'b0; rght_opn = 1'b0;
    mv_cmplt = 1'b0; sol_cmplt = 1'b0; cur_aff = 1'b0; cur_hd = 12'h000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({strt_mv, strt_hdng, stp_lft, stp_rght, dsrd_hdng}), 32'd0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("cmd_mode_idle", 32'({strt_mv, strt_hdng, stp_lft, stp_rght, dsrd_hdng}), 32'd0);
    end
    tick();

    for (int i = 0; i < 8; i++) begin
      start_solve(tbl[i].aff);
      move_done(tbl[i].lft, tbl[i].rght, tbl[i].exp_hdng);
    end

    // Four left turns in one left-affinity solve wrap back to NORTH.
    start_solve(1'b1);
    move_done(1'b1, 1'b0, 12'h3FF);
    move_done(1'b1, 1'b0, 12'h7FF);
    move_done(1'b1, 1'b0, 12'hC00);
    move_done(1'b1, 1'b0, 12'h000);

    // Abort in WAIT_HDNG together with mv_cmplt: command mode must win.
    lft_opn  = 1'b1;
    mv_cmplt = 1'b1;
    expect_pulse(1'b1, 12'h3FF, cyc + 2);
    tick();
    mv_cmplt = 1'b0;
    tick();
    lft_opn = 1'b0;
    tick();
    tick();
    cur_hd   = 12'h3FF;
    cmd_md   = 1'b1;
    mv_cmplt = 1'b1;
    tick();
    mv_cmplt = 1'b0;
    @(negedge clk);
    chk("abort_stp", 32'({stp_lft, stp_rght}), 32'd0);
    chk("abort_hdng_kept", 32'(dsrd_hdng), 32'h3FF);
    tick();
    mv_cmplt = 1'b1;
    tick();
    mv_cmplt = 1'b0;
    tick();

    // Solve complete, then spurious mv_cmplt and a long quiet spell in DONE.
    start_solve(1'b1);
    sol_cmplt = 1'b1;
    mv_cmplt  = 1'b1;
    tick();
    mv_cmplt  = 1'b0;
    sol_cmplt = 1'b0;
    @(negedge clk);
    chk("done_stp", 32'({stp_lft, stp_rght}), 32'd0);
    tick();
    mv_cmplt = 1'b1;
    tick();
    mv_cmplt = 1'b0;
    repeat (50) tick();
    chk("done_hdng_kept", 32'(dsrd_hdng), 32'h3FF);

    // Restart with right affinity; heading carried over.
    start_solve(1'b0);
    move_done(1'b0, 1'b0, 12'hC00);

    cmd_md = 1'b1;
    repeat (4) tick();
    chk("sb_pending", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
